// File: rtl/musa_mem_pkg.sv
// musa_mem_pkg: shared data-memory widths, requester IDs and arbitration mode encodings.
package musa_mem_pkg;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int ARB_PRIO = 0;
  localparam int ARB_RR = 1;
  typedef enum logic {
    REQ_CORE = 1'b0,
    REQ_HOST = 1'b1
  } req_id_e;
endpackage

// File: rtl/dmem_arb_pick.sv
// dmem_arb_pick: grant decision between core and host with aging, round-robin and host lock state.
module dmem_arb_pick
  import musa_mem_pkg::*;
#(
  parameter int ARB_MODE = ARB_PRIO,
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic core_req,
  input  logic host_req,
  input  logic host_lock,
  output logic core_gnt,
  output logic host_gnt
);
  localparam int CW = $clog2(MAX_WAIT + 1);
  logic [CW-1:0] wait_cnt;
  req_id_e last_gnt;
  logic lock_q;
  logic host_win;
  // An active lock only exists after a host grant, so it holds rather than preempts.
  always_comb begin
    host_win = lock_q | ((ARB_MODE == ARB_RR) ? (last_gnt == REQ_CORE) : (wait_cnt == CW'(MAX_WAIT)));
    host_gnt = host_req & (~core_req | host_win);
    core_gnt = core_req & ~host_gnt;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt <= '0;
      last_gnt <= REQ_HOST;
      lock_q   <= 1'b0;
    end else begin
      wait_cnt <= (host_req & ~host_gnt) ? ((wait_cnt == CW'(MAX_WAIT)) ? wait_cnt : wait_cnt + 1'b1) : '0;
      if (core_gnt | host_gnt) last_gnt <= host_gnt ? REQ_HOST : REQ_CORE;
      lock_q <= host_gnt & host_lock;
    end
  end
  assert property (@(posedge clk) disable iff (!rst_n) !(core_gnt && host_gnt));
  assert property (@(posedge clk) disable iff (!rst_n) wait_cnt <= CW'(MAX_WAIT));
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between core and host, routing
// the access to memory and returning registered read data to the requester that issued it.
module dmem_arbiter
  import musa_mem_pkg::*;
#(
  parameter int ADDR_W   = musa_mem_pkg::ADDR_W,
  parameter int DATA_W   = musa_mem_pkg::DATA_W,
  parameter int ARB_MODE = ARB_PRIO,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_gnt,
  output logic              core_stall,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic              host_lock,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q
);
  logic req_c, req_h;
  logic rd_pend;
  req_id_e rd_owner;
  logic [DATA_W-1:0] core_hold, host_hold;
  // Requests are masked in reset so every output reads zero while rst_n is low.
  assign req_c = rst_n & core_req;
  assign req_h = rst_n & host_req;
  dmem_arb_pick #(.ARB_MODE(ARB_MODE), .MAX_WAIT(MAX_WAIT)) u_pick (
    .clk      (clk),
    .rst_n    (rst_n),
    .core_req (req_c),
    .host_req (req_h),
    .host_lock(host_lock),
    .core_gnt (core_gnt),
    .host_gnt (host_gnt)
  );
  always_comb begin
    mem_addr    = host_gnt ? host_addr : core_gnt ? core_addr : '0;
    mem_data    = host_gnt ? host_wdata : core_gnt ? core_wdata : '0;
    mem_wren    = (host_gnt & host_we) | (core_gnt & core_we);
    core_stall  = req_c & ~core_gnt;
    core_rvalid = rst_n & rd_pend & (rd_owner == REQ_CORE);
    host_rvalid = rst_n & rd_pend & (rd_owner == REQ_HOST);
    core_rdata  = !rst_n ? '0 : core_rvalid ? mem_q : core_hold;
    host_rdata  = !rst_n ? '0 : host_rvalid ? mem_q : host_hold;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_pend   <= 1'b0;
      rd_owner  <= REQ_CORE;
      core_hold <= '0;
      host_hold <= '0;
    end else begin
      rd_pend  <= (core_gnt & ~core_we) | (host_gnt & ~host_we);
      rd_owner <= host_gnt ? REQ_HOST : REQ_CORE;
      if (core_rvalid) core_hold <= mem_q;
      if (host_rvalid) host_hold <= mem_q;
    end
  end
  assert property (@(posedge clk) !(core_rvalid && host_rvalid));
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scoreboard bench for dmem_arbiter in both arbitration modes.
module tb_dmem_arbiter;
  import musa_mem_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic core_req = 0, core_we = 0, host_req = 0, host_we = 0, host_lock = 0;
  logic [7:0] core_addr = 0, host_addr = 0;
  logic [31:0] core_wdata = 0, host_wdata = 0;
  logic core_gnt, core_stall, core_rvalid, host_gnt, host_rvalid, mem_wren;
  logic [31:0] core_rdata, host_rdata, mem_data, mem_q;
  logic [7:0] mem_addr;
  logic core_gnt_1, core_stall_1, core_rvalid_1, host_gnt_1, host_rvalid_1, mem_wren_1;
  logic [31:0] core_rdata_1, host_rdata_1, mem_data_1, mem_q_1;
  logic [7:0] mem_addr_1;
  logic [31:0] mem0 [256];
  logic [31:0] mem1 [256];
  int n_chk = 0, n_fail = 0;
  logic [31:0] q_core[$], q_host[$];

  dmem_arbiter #(.ARB_MODE(0), .MAX_WAIT(4)) u0 (
    .clk(clk), .rst_n(rst_n),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_stall(core_stall), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_lock(host_lock), .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_wren(mem_wren), .mem_q(mem_q)
  );
  dmem_arbiter #(.ARB_MODE(1), .MAX_WAIT(4)) u1 (
    .clk(clk), .rst_n(rst_n),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt_1), .core_stall(core_stall_1), .core_rvalid(core_rvalid_1), .core_rdata(core_rdata_1),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_lock(host_lock), .host_gnt(host_gnt_1), .host_rvalid(host_rvalid_1), .host_rdata(host_rdata_1),
    .mem_addr(mem_addr_1), .mem_data(mem_data_1), .mem_wren(mem_wren_1), .mem_q(mem_q_1)
  );

  // Registered-read memories standing in for data_memory.
  always @(posedge clk) begin
    if (mem_wren) mem0[mem_addr] <= mem_data;
    mem_q <= mem0[mem_addr];
    if (mem_wren_1) mem1[mem_addr_1] <= mem_data_1;
    mem_q_1 <= mem1[mem_addr_1];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every read return pops the expected value pushed by the stimulus.
  always @(negedge clk) begin
    if (core_rvalid) begin
      if (q_core.size() == 0) chk("core_rvalid_unexpected", 32'd1, 32'd0);
      else chk("core_rdata", core_rdata, q_core.pop_front());
    end
    if (host_rvalid) begin
      if (q_host.size() == 0) chk("host_rvalid_unexpected", 32'd1, 32'd0);
      else chk("host_rdata", host_rdata, q_host.pop_front());
    end
  end

  task automatic step(input logic cr, input logic cw, input logic [7:0] ca, input logic [31:0] cd,
                      input logic hr, input logic hw, input logic [7:0] ha, input logic [31:0] hd,
                      input logic hl);
    @(posedge clk);
    #1;
    core_req = cr; core_we = cw; core_addr = ca; core_wdata = cd;
    host_req = hr; host_we = hw; host_addr = ha; host_wdata = hd; host_lock = hl;
    @(negedge clk);
  endtask

  task automatic idle();
    step(0, 0, 8'h00, 32'h0, 0, 0, 8'h00, 32'h0, 0);
  endtask

  initial begin
    logic e;
    mem0[8'h10] = 32'hDEADBEEF;
    mem1[8'h10] = 32'hDEADBEEF;
    idle();
    idle();
    chk("reset_core_gnt", {31'd0, core_gnt}, 32'd0);
    chk("reset_mem_addr", {24'd0, mem_addr}, 32'd0);
    chk("reset_core_rdata", core_rdata, 32'd0);
    rst_n = 1'b1;
    // core read alone
    step(1, 0, 8'h10, 32'h0, 0, 0, 8'h00, 32'h0, 0);
    chk("t1_core_gnt", {31'd0, core_gnt}, 32'd1);
    chk("t1_host_gnt", {31'd0, host_gnt}, 32'd0);
    chk("t1_mem_addr", {24'd0, mem_addr}, 32'h10);
    chk("t1_mem_wren", {31'd0, mem_wren}, 32'd0);
    chk("t1_stall", {31'd0, core_stall}, 32'd0);
    q_core.push_back(32'hDEADBEEF);
    idle();
    chk("t1_core_rvalid", {31'd0, core_rvalid}, 32'd1);
    chk("t1_host_rvalid", {31'd0, host_rvalid}, 32'd0);
    // both requesting, priority with aging: 4 core grants then 1 host grant
    for (int i = 0; i < 10; i++) begin
      step(1, 1, 8'h40, i, 1, 1, 8'h41, i, 0);
      e = (i % 5 == 4);
      chk($sformatf("t2_host_gnt_%0d", i), {31'd0, host_gnt}, {31'd0, e});
      chk($sformatf("t2_core_gnt_%0d", i), {31'd0, core_gnt}, {31'd0, ~e});
      chk($sformatf("t2_stall_%0d", i), {31'd0, core_stall}, {31'd0, e});
      chk($sformatf("t2_mem_addr_%0d", i), {24'd0, mem_addr}, e ? 32'h41 : 32'h40);
    end
    idle();
    // host lock burst: aging wins the first grant, lock holds two more
    for (int i = 0; i < 7; i++) begin
      step(1, 1, 8'h50, 32'h0, 1, 1, 8'h20, 32'hA5A5A5A5, 1);
      e = (i >= 4);
      chk($sformatf("t4_host_gnt_%0d", i), {31'd0, host_gnt}, {31'd0, e});
      chk($sformatf("t4_stall_%0d", i), {31'd0, core_stall}, {31'd0, e});
    end
    step(1, 1, 8'h50, 32'h0, 0, 0, 8'h00, 32'h0, 0);
    chk("t4_core_gnt_after", {31'd0, core_gnt}, 32'd1);
    chk("t4_stall_after", {31'd0, core_stall}, 32'd0);
    idle();
    // host write then core read of the same word
    step(0, 0, 8'h00, 32'h0, 1, 1, 8'h05, 32'h12345678, 0);
    chk("t6_host_gnt", {31'd0, host_gnt}, 32'd1);
    chk("t6_mem_wren", {31'd0, mem_wren}, 32'd1);
    chk("t6_mem_data", mem_data, 32'h12345678);
    step(1, 0, 8'h05, 32'h0, 0, 0, 8'h00, 32'h0, 0);
    q_core.push_back(32'h12345678);
    step(0, 0, 8'h00, 32'h0, 1, 0, 8'h20, 32'h0, 0);
    q_host.push_back(32'hA5A5A5A5);
    idle();
    chk("t6_core_rvalid_clear", {31'd0, core_rvalid}, 32'd0);
    chk("t6_core_rdata_hold", core_rdata, 32'h12345678);
    // reset while a read is pending
    step(1, 0, 8'h10, 32'h0, 0, 0, 8'h00, 32'h0, 0);
    chk("t5_core_gnt", {31'd0, core_gnt}, 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("t5_rst_core_gnt", {31'd0, core_gnt}, 32'd0);
    chk("t5_rst_stall", {31'd0, core_stall}, 32'd0);
    chk("t5_rst_core_rvalid", {31'd0, core_rvalid}, 32'd0);
    chk("t5_rst_host_rvalid", {31'd0, host_rvalid}, 32'd0);
    chk("t5_rst_mem_wren", {31'd0, mem_wren}, 32'd0);
    chk("t5_rst_mem_addr", {24'd0, mem_addr}, 32'd0);
    chk("t5_rst_mem_data", mem_data, 32'd0);
    chk("t5_rst_core_rdata", core_rdata, 32'd0);
    chk("t5_rst_host_rdata", host_rdata, 32'd0);
    step(1, 0, 8'h10, 32'h0, 0, 0, 8'h00, 32'h0, 0);
    chk("t5_rst2_core_rvalid", {31'd0, core_rvalid}, 32'd0);
    rst_n = 1'b1;
    step(1, 0, 8'h10, 32'h0, 0, 0, 8'h00, 32'h0, 0);
    chk("t5_post_core_gnt", {31'd0, core_gnt}, 32'd1);
    q_core.push_back(32'hDEADBEEF);
    idle();
    chk("t5_post_core_rvalid", {31'd0, core_rvalid}, 32'd1);
    // round-robin instance from a fresh reset
    rst_n = 1'b0;
    idle();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(1, 1, 8'h60, 32'h0, 1, 1, 8'h61, 32'h0, 0);
      e = (i % 2 == 1);
      chk($sformatf("t3_host_gnt_%0d", i), {31'd0, host_gnt_1}, {31'd0, e});
      chk($sformatf("t3_core_gnt_%0d", i), {31'd0, core_gnt_1}, {31'd0, ~e});
    end
    idle();
    idle();
    chk("core_queue_empty", q_core.size(), 32'd0);
    chk("host_queue_empty", q_host.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
